ps2_rx_frame: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_rx_frame.sv | 172 +++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_STOP = 2'd2
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_START   = 2'd0,
    ERR_PARITY  = 2'd1,
    ERR_STOP    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ps2_err_e;

  localparam int FRAME_LEN = 11;
  localparam int DATA_W    = 8;
  localparam int PAYLOAD_W = DATA_W + 1;
  // bits shifted in while in RECV: everything between start and stop
  localparam int RECV_BITS = FRAME_LEN - 2;
  localparam int BIT_CNT_W = $clog2(RECV_BITS + 1);

  function automatic logic odd_parity_ok(input logic [PAYLOAD_W-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the line after FILTER_LEN consecutive identical samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  always_comb begin
    sync_d = {sync_q[0], line_raw};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // idle PS/2 lines are high, so everything resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional inter-edge timeout is built when PS2_RX_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for the start-bit falling edge
// RECV  | shifting in 8 data bits then the parity bit
// STOP  | waiting for the stop bit, then check and report
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
`ifdef PS2_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 5000
`endif
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [7:0]  DATA,
  output logic        VALID,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic        BUSY
);

  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_filt;
  logic       clk_prev_q, clk_prev_d;
  logic       clk_fall;
  logic       data_bit;
  logic       timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (CLK_50M),
    .rst_n     (RST_N),
    .line_raw  (PS2_CLK),
    .line_filt (clk_filt)
  );

  always_comb begin
    data_sync_d = {data_sync_q[0], PS2_DATA};
    clk_prev_d  = clk_filt;
    clk_fall    = clk_prev_q & ~clk_filt;
    data_bit    = data_sync_q[1];
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  ps2_state_e             state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [PAYLOAD_W-1:0]   shift_q;
  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   err_q;
  ps2_err_e               err_code_q;
  logic                   busy_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOUT_W-1:0] tout_q, tout_d;
  logic              clk_edge;

  always_comb begin
    clk_edge = clk_filt ^ clk_prev_q;
    tout_d   = tout_q + 1'b1;
    // the edge is seen one cycle after the filter flipped, so restart at 1
    if (clk_edge) begin
      tout_d = TOUT_W'(1);
    end else if (state_q == ST_IDLE) begin
      tout_d = '0;
    end
    timeout_hit = (state_q != ST_IDLE) && !clk_edge &&
                  (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tout_q <= '0;
    end else begin
      tout_q <= tout_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_START;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clk_fall) begin
            if (!data_bit) begin
              state_q   <= ST_RECV;
              bit_cnt_q <= '0;
              busy_q    <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_START;
            end
          end
        end
        ST_RECV: begin
          if (clk_fall) begin
            shift_q   <= {data_bit, shift_q[PAYLOAD_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(RECV_BITS - 1)) begin
              state_q <= ST_STOP;
            end
          end else if (timeout_hit) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        ST_STOP: begin
          if (clk_fall) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (!data_bit) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_STOP;
            end else if (!odd_parity_ok(shift_q)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_PARITY;
            end else begin
              data_q  <= shift_q[DATA_W-1:0];
              valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA     = data_q;
  assign VALID    = valid_q;
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: PS/2 device model plus a frame-level outcome model.
// Timeout scenario depends on PS2_RX_TIMEOUT_EN.
module tb_ps2_rx_frame;

  localparam int HALF = 60;
  localparam int FILT = 8;
  localparam int TOUT = 5000;

  logic       CLK_50M  = 1'b0;
  logic       RST_N    = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       ERR;
  logic [1:0] ERR_CODE;
  logic       BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  int         vcnt = 0;
  int         ecnt = 0;
  int         both_cnt = 0;
  logic [7:0] vdata = 8'h00;

  logic [7:0] exp_data = 8'h00;
  logic [1:0] exp_code = 2'd0;

  always #10 CLK_50M = ~CLK_50M;

  ps2_rx_frame #(.FILTER_LEN(FILT)) dut (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .DATA     (DATA),
    .VALID    (VALID),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE),
    .BUSY     (BUSY)
  );

  always @(negedge CLK_50M) begin
    if (VALID) begin
      vcnt  <= vcnt + 1;
      vdata <= DATA;
    end
    if (ERR) ecnt <= ecnt + 1;
    if (VALID && ERR) both_cnt <= both_cnt + 1;
  end

  // outcome of a start-0 frame: -1 for a good byte, else the error code
  function automatic int frame_outcome(input logic [7:0] d, input logic par, input logic stp);
    if (!stp) return 2;
    if ((($countones(d) + int'(par)) % 2) != 1) return 1;
    return -1;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_50M);
  endtask

  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wait_cyc(HALF / 2);
      PS2_DATA = f[i];
      wait_cyc(HALF / 2);
      PS2_CLK = 1'b0;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic send_idle();
    wait_cyc(HALF / 2);
    PS2_DATA = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    wait_cyc(3);
    n_cmp++; if (DATA !== 8'h00)   begin n_fail++; $display("FAIL reset_data: got %0h expected 0", DATA); end
    n_cmp++; if (VALID !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", VALID); end
    n_cmp++; if (ERR !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %0b expected 0", ERR); end
    n_cmp++; if (ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d expected 0", ERR_CODE); end
    n_cmp++; if (BUSY !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", BUSY); end
    RST_N = 1'b1;
    wait_cyc(30);
    n_cmp++; if (ecnt !== 0 || BUSY !== 1'b0)
      begin n_fail++; $display("FAIL reset_quiet: got err_count %0d busy %0b expected 0 0", ecnt, BUSY); end
  endtask

  task automatic test_good_frame();
    int v0, e0;
    logic [10:0] f;
    v0 = vcnt; e0 = ecnt;
    f = mk_frame(8'hFA, 1'b1, 1'b1);
    send_range(f, 0, 2);
    n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %0b expected 1", BUSY); end
    send_range(f, 3, 10);
    send_idle();
    exp_data = 8'hFA;
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL good_valid_cycles: got %0d expected 1", vcnt - v0); end
    n_cmp++; if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL good_err_count: got %0d expected 0", ecnt - e0); end
    n_cmp++; if (vdata !== exp_data) begin n_fail++; $display("FAIL good_data_at_valid: got %0h expected %0h", vdata, exp_data); end
    n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL good_data_held: got %0h expected %0h", DATA, exp_data); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %0b expected 0", BUSY); end
  endtask

  task automatic test_parity_err();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_range(mk_frame(8'hFA, 1'b0, 1'b1), 0, 10);
    send_idle();
    exp_code = 2'd1;
    n_cmp++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL parity_valid: got %0d expected 0", vcnt - v0); end
    n_cmp++; if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL parity_err_count: got %0d expected 1", ecnt - e0); end
    n_cmp++; if (ERR_CODE !== exp_code) begin n_fail++; $display("FAIL parity_code: got %0d expected %0d", ERR_CODE, exp_code); end
    n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL parity_data_kept: got %0h expected %0h", DATA, exp_data); end
  endtask

  task automatic test_stop_err();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_range(mk_frame(8'h00, 1'b0, 1'b0), 0, 10);
    send_idle();
    exp_code = 2'd2;
    n_cmp++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL stop_valid: got %0d expected 0", vcnt - v0); end
    n_cmp++; if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL stop_err_count: got %0d expected 1", ecnt - e0); end
    n_cmp++; if (ERR_CODE !== exp_code) begin n_fail++; $display("FAIL stop_code: got %0d expected %0d", ERR_CODE, exp_code); end
    n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL stop_data_kept: got %0h expected %0h", DATA, exp_data); end
  endtask

  task automatic test_glitch();
    int  e0;
    logic busy_seen;
    e0 = ecnt;
    busy_seen = 1'b0;
    PS2_DATA = 1'b1;
    PS2_CLK = 1'b0;
    wait_cyc(5);
    PS2_CLK = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_50M);
      if (BUSY) busy_seen = 1'b1;
    end
    n_cmp++; if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL glitch5_err: got %0d expected 0", ecnt - e0); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL glitch5_busy: got %0b expected 0", busy_seen); end
    PS2_CLK = 1'b0;
    wait_cyc(9);
    PS2_CLK = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_50M);
      if (BUSY) busy_seen = 1'b1;
    end
    exp_code = 2'd0;
    n_cmp++; if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL glitch9_err: got %0d expected 1", ecnt - e0); end
    n_cmp++; if (ERR_CODE !== exp_code) begin n_fail++; $display("FAIL glitch9_code: got %0d expected %0d", ERR_CODE, exp_code); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL glitch9_busy: got %0b expected 0", busy_seen); end
  endtask

  task automatic test_timeout();
    int  e0, v0, n;
    logic found;
    e0 = ecnt;
    found = 1'b0;
    n = 0;
    send_range(mk_frame(8'h5A, 1'b1, 1'b1), 0, 4);
`ifdef PS2_RX_TIMEOUT_EN
    while (n < TOUT + 1000) begin
      @(posedge CLK_50M);
      n++;
      #1;
      if (ERR) begin
        found = 1'b1;
        break;
      end
    end
    wait_cyc(2);
    exp_code = 2'd3;
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: got %0b expected 1", found); end
    n_cmp++; if (n !== TOUT + FILT + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", n, TOUT + FILT + 2); end
    n_cmp++; if (ERR_CODE !== exp_code) begin n_fail++; $display("FAIL timeout_code: got %0d expected %0d", ERR_CODE, exp_code); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %0b expected 0", BUSY); end
`else
    wait_cyc(TOUT + 1000);
    n_cmp++; if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL no_timeout_err: got %0d expected 0", ecnt - e0); end
    n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL no_timeout_busy: got %0b expected 1", BUSY); end
    RST_N = 1'b0;
    wait_cyc(2);
    RST_N = 1'b1;
    exp_data = 8'h00;
    exp_code = 2'd0;
    wait_cyc(20);
    e0 = ecnt;
    n = int'(found);
`endif
    v0 = vcnt;
    send_range(mk_frame(8'h08, 1'b0, 1'b1), 0, 10);
    send_idle();
    exp_data = 8'h08;
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL resync_valid: got %0d expected 1", vcnt - v0); end
    n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL resync_data: got %0h expected %0h", DATA, exp_data); end
  endtask

  task automatic test_reset_mid();
    int e0, v0;
    e0 = ecnt;
    send_range(mk_frame(8'h33, 1'b1, 1'b1), 0, 4);
    wait_cyc(HALF / 2);
    PS2_CLK = 1'b0;
    wait_cyc(HALF / 3);
    RST_N = 1'b0;
    #1;
    n_cmp++; if ({DATA, VALID, ERR, ERR_CODE, BUSY} !== 13'd0)
      begin n_fail++; $display("FAIL rst_mid_async: got %0h expected 0", {DATA, VALID, ERR, ERR_CODE, BUSY}); end
    exp_data = 8'h00;
    exp_code = 2'd0;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    wait_cyc(4);
    RST_N = 1'b1;
    wait_cyc(30);
    n_cmp++; if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_err: got %0d expected 0", ecnt - e0); end
    v0 = vcnt;
    send_range(mk_frame(8'h55, 1'b1, 1'b1), 0, 10);
    send_idle();
    exp_data = 8'h55;
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rst_mid_valid: got %0d expected 1", vcnt - v0); end
    n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL rst_mid_data: got %0h expected %0h", DATA, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       par, stp;
    int         oc, v0, e0, exp_v, exp_e;
    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom);
      par = ~^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 3) != 0);
      oc  = frame_outcome(d, par, stp);
      v0 = vcnt; e0 = ecnt;
      send_range(mk_frame(d, par, stp), 0, 10);
      send_idle();
      if (oc < 0) begin
        exp_v = 1; exp_e = 0; exp_data = d;
      end else begin
        exp_v = 0; exp_e = 1; exp_code = 2'(oc);
      end
      n_cmp++; if (vcnt - v0 !== exp_v) begin n_fail++; $display("FAIL rand%0d_valid: got %0d expected %0d", k, vcnt - v0, exp_v); end
      n_cmp++; if (ecnt - e0 !== exp_e) begin n_fail++; $display("FAIL rand%0d_err: got %0d expected %0d", k, ecnt - e0, exp_e); end
      n_cmp++; if (DATA !== exp_data) begin n_fail++; $display("FAIL rand%0d_data: got %0h expected %0h", k, DATA, exp_data); end
      n_cmp++; if (ERR_CODE !== exp_code) begin n_fail++; $display("FAIL rand%0d_code: got %0d expected %0d", k, ERR_CODE, exp_code); end
      n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %0b expected 0", k, BUSY); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
